// File: rtl/cim_pkg.sv
// Shared types and helpers for the tile-accumulate controller.
// Holds tile geometry, tile type, memory-word packing and FSM states.
package cim_pkg;

    localparam int TILE_N    = 6;
    localparam int ELEM_W    = 12;
    localparam int MEM_W     = 512;
    localparam int TILE_BITS = TILE_N * TILE_N * ELEM_W;

    typedef logic signed [TILE_N-1:0][TILE_N-1:0][ELEM_W-1:0] tile_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE
    } state_t;

    // Element [i][j] lives at bits [(6i+j)*12 +: 12]; upper bits are zero.
    function automatic logic [MEM_W-1:0] tile_pack(input tile_t t);
        logic [MEM_W-1:0] w;
        w = '0;
        for (int i = 0; i < TILE_N; i++) begin
            for (int j = 0; j < TILE_N; j++) begin
                w[(TILE_N*i+j)*ELEM_W +: ELEM_W] = t[i][j];
            end
        end
        return w;
    endfunction

    function automatic tile_t tile_unpack(input logic [MEM_W-1:0] w);
        tile_t t;
        for (int i = 0; i < TILE_N; i++) begin
            for (int j = 0; j < TILE_N; j++) begin
                t[i][j] = w[(TILE_N*i+j)*ELEM_W +: ELEM_W];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/cim_tile_add.sv
// 36-lane element-wise tile adder.
// Each lane is a 12-bit two's-complement add that wraps on overflow.
module cim_tile_add
    import cim_pkg::*;
(
    input  tile_t a_i,
    input  tile_t b_i,
    output tile_t sum_o
);

    // Lane-wise wrapping add; carry out of bit 11 is discarded.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < TILE_N; i++) begin
            for (int j = 0; j < TILE_N; j++) begin
                sum_o[i][j] = a_i[i][j] + b_i[i][j];
            end
        end
    end

endmodule

// File: rtl/cim_accum_ctrl.sv
// Tile-accumulate sequencer: read partial sum, add PE tile, write back.
// One tile in flight at a time, so no read-modify-write hazards exist.
module cim_accum_ctrl
    import cim_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  tile_t             pe_tile_i,
    input  logic [ADDR_W-1:0] pe_addr_i,
    input  logic              pe_first_i,
    input  logic              pe_valid_i,
    output logic              pe_ready_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [MEM_W-1:0]  mem_rd_data_i,
    output logic [MEM_W-1:0]  mem_wr_data_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  acc_count_o
);

    localparam int WC_W = $clog2(RD_LAT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [WC_W-1:0]   r_wait;
    tile_t             r_pe;
    tile_t             r_mem;
    tile_t             w_sum;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic              w_accept;
    logic              w_unused;

    assign w_accept = (r_state == ST_IDLE) && pe_valid_i;
    assign w_unused = ^mem_rd_data_i[MEM_W-1:TILE_BITS];

    cim_tile_add u_add (
        .a_i   (r_mem),
        .b_i   (r_pe),
        .sum_o (w_sum)
    );

    // State register; reset aborts any pending read or write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next      = r_state;
        pe_ready_o  = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        done_o      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                pe_ready_o = 1'b1;
                if (pe_valid_i) begin
                    w_next = pe_first_i ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_en_o = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait == WC_W'(1)) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wr_en_o = 1'b1;
                done_o      = 1'b1;
                w_next      = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Tile/address capture, read-latency countdown and completion count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pe    <= '0;
            r_mem   <= '0;
            r_addr  <= '0;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_pe   <= pe_tile_i;
                r_addr <= pe_addr_i;
                if (pe_first_i) r_mem <= '0;
            end
            if (r_state == ST_READ) begin
                r_wait <= WC_W'(RD_LAT);
            end
            if (r_state == ST_WAIT) begin
                r_wait <= r_wait - WC_W'(1);
                if (r_wait == WC_W'(1)) begin
                    r_mem <= tile_unpack(mem_rd_data_i);
                end
            end
            if (r_state == ST_WRITE) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign mem_addr_o    = r_addr;
    assign mem_wr_data_o = tile_pack(w_sum);
    assign acc_count_o   = r_count;

endmodule

// File: tb/tb_cim_accum_ctrl.sv
// Scoreboard bench for cim_accum_ctrl with a latency-modelled memory.
// Expected writes come from a shadow memory updated with plain arithmetic.
module tb_cim_accum_ctrl;
    import cim_pkg::*;

    localparam int RD_LAT = 3;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset;
    tile_t             pe_tile;
    logic [ADDR_W-1:0] pe_addr;
    logic              pe_first;
    logic              pe_valid;
    logic              pe_ready;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] maddr;
    logic [511:0]      rd_data;
    logic [511:0]      wr_data;
    logic              done;
    logic [CNT_W-1:0]  acc_count;

    cim_accum_ctrl #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pe_tile_i     (pe_tile),
        .pe_addr_i     (pe_addr),
        .pe_first_i    (pe_first),
        .pe_valid_i    (pe_valid),
        .pe_ready_o    (pe_ready),
        .mem_rd_en_o   (rd_en),
        .mem_wr_en_o   (wr_en),
        .mem_addr_o    (maddr),
        .mem_rd_data_i (rd_data),
        .mem_wr_data_o (wr_data),
        .done_o        (done),
        .acc_count_o   (acc_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    // Memory model: RD_LAT-deep return pipe, junk outside the data cycle.
    logic [511:0] mem     [256];
    logic [511:0] ref_mem [256];
    logic         pv [RD_LAT];
    logic [511:0] pd [RD_LAT];
    logic [511:0] junk;
    logic         bd_en = 1'b0;
    logic [7:0]   bd_addr;
    logic [511:0] bd_data;

    always @(posedge clock) begin
        pv[0] <= rd_en;
        pd[0] <= mem[maddr];
        for (int k = 1; k < RD_LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        for (int k = 0; k < 16; k++) junk[k*32 +: 32] <= $urandom;
        if (wr_en) mem[maddr] <= wr_data;
        if (bd_en) mem[bd_addr] <= bd_data;
    end

    assign rd_data = pv[RD_LAT-1] ? pd[RD_LAT-1] : junk;

    typedef struct {
        int           cyc;
        logic [7:0]   addr;
        logic [511:0] data;
    } wr_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } rd_exp_t;

    wr_exp_t wq[$];
    rd_exp_t rq[$];

    task automatic chk(input string nm, input logic [511:0] a,
                       input logic [511:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    // Reference: per-element signed add reduced modulo 4096.
    function automatic logic [511:0] model_sum(input logic [511:0] old,
                                               input logic [431:0] t,
                                               input bit first);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 36; k++) begin
            int a;
            int b;
            int s;
            logic [11:0] ea;
            logic [11:0] eb;
            ea = old[k*12 +: 12];
            eb = t[k*12 +: 12];
            a = first ? 0 : int'($signed(ea));
            b = int'($signed(eb));
            s = ((a + b) % 4096 + 4096) % 4096;
            r[k*12 +: 12] = 12'(s);
        end
        return r;
    endfunction

    function automatic logic [431:0] fill(input logic [11:0] v);
        logic [431:0] r;
        for (int k = 0; k < 36; k++) r[k*12 +: 12] = v;
        return r;
    endfunction

    function automatic logic [431:0] rand_tile();
        logic [431:0] r;
        for (int k = 0; k < 36; k++) r[k*12 +: 12] = 12'($urandom);
        return r;
    endfunction

    function automatic logic [511:0] rand_word();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: every read and write strobe must match a queued expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (rd_en) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_read");
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    chk("rd_addr", 512'(maddr), 512'(e.addr));
                    chk("rd_cycle", 512'(cyc), 512'(e.cyc));
                end
            end
            if (wr_en) begin
                if (wq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 512'(maddr), 512'(e.addr));
                    chk("wr_data", wr_data, e.data);
                    chk("wr_cycle", 512'(cyc), 512'(e.cyc));
                    chk("done_with_write", 512'(done), 512'(1));
                end
            end else if (done) begin
                fail_now("done_without_write");
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [511:0] d);
        @(negedge clock);
        bd_en   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        @(negedge clock);
        bd_en = 1'b0;
    endtask

    task automatic expect_tile(input logic [7:0] a, input bit f,
                               input logic [431:0] t, input int c);
        logic [511:0] d;
        if (!f) rq.push_back('{c + 1, a});
        d = model_sum(ref_mem[a], t, f);
        ref_mem[a] = d;
        wq.push_back('{c + (f ? 1 : RD_LAT + 2), a, d});
        exp_count++;
    endtask

    // Present a tile; returns at the cycle whose closing edge accepts it.
    task automatic send(input logic [7:0] a, input bit f,
                        input logic [431:0] t, output int tacc);
        int guard;
        guard = 0;
        tacc  = -1;
        @(negedge clock);
        pe_addr  = a;
        pe_first = f;
        pe_tile  = tile_t'(t);
        pe_valid = 1'b1;
        while (!pe_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) begin
            fail_now("accept_timeout");
        end else begin
            tacc = cyc;
            expect_tile(a, f, t, cyc);
        end
    endtask

    task automatic drop_valid();
        @(negedge clock);
        pe_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((wq.size() != 0 || rq.size() != 0) && g < 200) begin
            @(negedge clock);
            g++;
        end
        if (g >= 200) fail_now("drain_timeout");
        @(negedge clock);
        chk("acc_count", 512'(acc_count), 512'(CNT_W'(exp_count)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ta;
        int tb;
        logic [511:0] w;
        logic [431:0] t;

        for (int k = 0; k < RD_LAT; k++) pv[k] = 1'b0;
        reset    = 1'b1;
        pe_valid = 1'b0;
        pe_first = 1'b0;
        pe_addr  = '0;
        pe_tile  = '0;
        repeat (3) @(negedge clock);

        chk("rst_ready", 512'(pe_ready), 512'(1));
        chk("rst_rd_en", 512'(rd_en), 512'(0));
        chk("rst_wr_en", 512'(wr_en), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_count", 512'(acc_count), 512'(0));
        chk("rst_addr", 512'(maddr), 512'(0));

        for (int a = 0; a < 32; a++) poke(8'(a), rand_word());
        @(negedge clock);
        reset = 1'b0;

        // Partial sum 100 plus tile 23 gives 123 everywhere.
        poke(8'h05, {80'(0), fill(12'd100)});
        send(8'h05, 1'b0, fill(12'd23), ta);
        drop_valid();
        drain();
        chk("sum_123", mem[5], {80'(0), fill(12'd123)});

        // Wrap-around lanes: 2047+1 and -5+-7.
        w = '0;
        w[11:0]  = 12'd2047;
        w[23:12] = 12'hFFB;
        poke(8'h06, w);
        t = '0;
        t[11:0]  = 12'd1;
        t[23:12] = 12'hFF9;
        send(8'h06, 1'b0, t, ta);
        drop_valid();
        drain();
        chk("wrap_pos", 512'(mem[6][11:0]), 512'(12'h800));
        chk("wrap_neg", 512'(mem[6][23:12]), 512'(12'hFF4));

        // First contribution ignores garbage already in memory.
        poke(8'h10, rand_word());
        send(8'h10, 1'b1, fill(12'd7), ta);
        drop_valid();
        drain();
        chk("first_7", mem[16], {80'(0), fill(12'd7)});

        // Back-to-back with valid held: spacing RD_LAT+3, or 2 for first.
        send(8'h01, 1'b0, rand_tile(), ta);
        send(8'h02, 1'b0, rand_tile(), tb);
        chk("b2b_spacing", 512'(tb - ta), 512'(RD_LAT + 3));
        send(8'h03, 1'b1, rand_tile(), ta);
        send(8'h04, 1'b1, rand_tile(), tb);
        chk("b2b_first_spacing", 512'(tb - ta), 512'(2));
        drop_valid();
        drain();

        // Reset while waiting on read data aborts the tile.
        @(negedge clock);
        pe_addr  = 8'h03;
        pe_first = 1'b0;
        pe_tile  = tile_t'(rand_tile());
        pe_valid = 1'b1;
        rq.push_back('{cyc + 1, 8'h03});
        @(negedge clock);
        pe_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ready", 512'(pe_ready), 512'(1));
        chk("abort_count", 512'(acc_count), 512'(0));
        chk("abort_rq_empty", 512'(rq.size()), 512'(0));
        exp_count = 0;
        t = rand_tile();
        pe_addr  = 8'h09;
        pe_first = 1'b1;
        pe_tile  = tile_t'(t);
        pe_valid = 1'b1;
        repeat (2) @(negedge clock);
        chk("abort_no_write", 512'(mem[3]), ref_mem[3]);
        reset = 1'b0;
        expect_tile(8'h09, 1'b1, t, cyc);
        drop_valid();
        drain();

        // Randomised traffic over a small address set for reuse.
        for (int n = 0; n < 60; n++) begin
            send(8'($urandom_range(0, 7)), ($urandom % 4) == 0,
                 rand_tile(), ta);
            if ($urandom % 2 == 0) begin
                drop_valid();
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
        end
        drop_valid();
        drain();
        for (int a = 0; a < 8; a++) chk("final_mem", mem[a], ref_mem[a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
